imem_loader: RTL
================

# imem_loader

Byte-stream loader that writes a program image into the instruction memory's word array before the core runs. It accepts a framed little-endian byte stream over a valid/ready handshake, assembles 32-bit instruction words and issues one write per word on the memory write port. It checks a length field and an XOR checksum, and reports `done` or `error` to the boot controller that releases the core.

## Interface

Parameters:
- `DEPTH`, 1024: instruction memory depth in 32-bit words.
- `ADDR_W`, 10: word-address width; DEPTH = 2^ADDR_W.

Ports:
- `clk`  in  1: single clock; all logic is on its rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle pulse that arms the loader for a new frame.
- `rx_data`  in  8: stream byte.
- `rx_valid`  in  1: `rx_data` is valid.
- `rx_ready`  out  1: the loader can accept a byte.
- `im_we`  out  1: instruction memory write strobe, one cycle per word.
- `im_addr`  out  ADDR_W: word address of the write (byte address >> 2).
- `im_wdata`  out  32: instruction word to write.
- `busy`  out  1: a frame is in progress.
- `done`  out  1: the frame loaded and the checksum matched.
- `error`  out  1: the length exceeded DEPTH or the checksum mismatched.
- `word_count`  out  ADDR_W+1: number of words written in the current or last frame.

## Operation

- Frame format: LEN_LO, LEN_HI, then N×4 data bytes, then CHK.
  - N = {LEN_HI, LEN_LO}, a 16-bit unsigned count.
  - Data bytes are little-endian per word: word = {b3, b2, b1, b0}.
  - CHK = XOR of all data bytes. With N = 0, CHK must be 8'h00.
- States: IDLE, LEN0, LEN1, DATA, CHK, DONE, ERROR.
- IDLE/DONE/ERROR to LEN0 on `start`. Entering LEN0 clears `done`, `error`, `word_count`, the byte lane counter and the checksum accumulator.
- `start` in LEN0, LEN1, DATA or CHK is ignored.
- LEN0 to LEN1 on an accepted byte, which is stored as LEN_LO.
- LEN1 on an accepted byte:
  - N > DEPTH: go to ERROR.
  - N = 0: go to CHK.
  - Otherwise: go to DATA.
- DATA:
  - Each accepted byte fills lane 0..3 and XORs into the checksum.
  - On lane 3, the assembled word is written to address `word_count`, then `word_count` increments.
  - Go to CHK after word N-1.
- CHK: on an accepted byte, go to DONE if it equals the accumulator, otherwise ERROR.
- Words already written are not rolled back on error.
- Handshake:
  - A byte transfers on a rising edge with `rx_valid` && `rx_ready`.
  - `rx_ready` = 1 in LEN0, LEN1, DATA and CHK, and 0 in IDLE, DONE and ERROR.
  - `rx_ready` decodes only the registered state, never `rx_valid`.
  - The sender may hold `rx_valid` for any number of cycles. Gaps between bytes are allowed.
- `busy` = 1 in LEN0, LEN1, DATA and CHK.
- `done` and `error` are levels held until the next accepted `start`.
- Width rules:
  - N compares against DEPTH at ADDR_W+1 bits after a 16-bit check; any nonzero bit above bit ADDR_W is an error.
  - N = DEPTH is legal and fills addresses 0..DEPTH-1.
  - `im_addr` never wraps.

## Timing

- Reset values: state IDLE; `rx_ready`, `im_we`, `busy`, `done` and `error` are 0; `im_addr`, `im_wdata` and `word_count` are 0.
- Asserting `reset_n` low mid-frame aborts immediately to IDLE with the reset values above. An `im_we` pulse pending at that moment is dropped.
- Memory write latency:
  - `im_we`, `im_addr` and `im_wdata` are registered.
  - `im_we` is high for exactly the one cycle after the edge that accepts lane 3.
  - `im_addr`/`im_wdata` are stable in that cycle.
  - `word_count` shows the incremented value in the same cycle.
- `done`/`error` rise in the cycle after the edge accepting CHK, or after LEN_HI for a length error.
- Maximum throughput is one byte per cycle; one word every 4 cycles.
- `start` together with `rx_valid` in IDLE: `start` is taken and the byte is not accepted (`rx_ready` = 0). The first byte can be accepted on the next edge.

## Test plan

- Reset then idle: all outputs 0 and `rx_ready` = 0; `rx_valid` pulses are ignored.
- Two-word frame at full rate:
  - Stream: 02 00 | 93 00 C0 2B | 13 91 80 01 | CHK = XOR of the eight data bytes.
  - Expect an `im_we` pulse with addr 0, data 2BC00093.
  - Expect an `im_we` pulse with addr 1, data 01809113.
  - Expect `done` = 1 the cycle after CHK, `word_count` = 2, `busy` = 0.
- Same frame with random `rx_valid` gaps: identical writes and `done`; no byte accepted while `rx_ready` = 0.
- Bad checksum (CHK XOR 01): both words written, `error` = 1, `done` = 0. A new `start` clears `error`.
- Length 0401 (1025 > DEPTH): `error` the cycle after LEN_HI, no `im_we`, `rx_ready` drops.
- `reset_n` low after 6 data bytes: immediate return to IDLE with outputs 0. A following full `start` frame writes from addr 0. N = 0 with CHK 00 gives `done` and `word_count` 0.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: framed little-endian byte-stream loader for the instruction memory.
// Frame: LEN_LO, LEN_HI, N*4 data bytes, CHK (XOR of all data bytes).
module imem_loader #(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERROR
    } state_e;

    state_e              state_q,      state_d;
    logic [7:0]          len_lo_q,     len_lo_d;
    logic [CNT_W-1:0]    n_q,          n_d;
    logic [1:0]          lane_q,       lane_d;
    logic [7:0]          chk_q,        chk_d;
    logic [23:0]         wbuf_q,       wbuf_d;
    logic [CNT_W-1:0]    word_count_q, word_count_d;
    logic                im_we_q,      im_we_d;
    logic [ADDR_W-1:0]   im_addr_q,    im_addr_d;
    logic [31:0]         im_wdata_q,   im_wdata_d;
    logic                done_q,       done_d;
    logic                error_q,      error_d;
    logic                rx_ready_q,   rx_ready_d;
    logic                busy_q,       busy_d;

    logic                accept_c;
    logic [15:0]         len_c;

    assign accept_c = rx_valid && rx_ready_q;
    assign len_c    = {rx_data, len_lo_q};

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d      = state_q;
        len_lo_d     = len_lo_q;
        n_d          = n_q;
        lane_d       = lane_q;
        chk_d        = chk_q;
        wbuf_d       = wbuf_q;
        word_count_d = word_count_q;
        im_we_d      = 1'b0;
        im_addr_d    = im_addr_q;
        im_wdata_d   = im_wdata_q;
        done_d       = done_q;
        error_d      = error_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d      = S_LEN0;
                    done_d       = 1'b0;
                    error_d      = 1'b0;
                    word_count_d = '0;
                    lane_d       = '0;
                    chk_d        = '0;
                end
            end
            S_LEN0: begin
                if (accept_c) begin
                    len_lo_d = rx_data;
                    state_d  = S_LEN1;
                end
            end
            S_LEN1: begin
                if (accept_c) begin
                    // Full 16-bit compare so any bit above ADDR_W flags an error
                    if (32'(len_c) > DEPTH) begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                    end else if (len_c == 16'd0) begin
                        state_d = S_CHK;
                    end else begin
                        n_d     = CNT_W'(len_c);
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept_c) begin
                    chk_d  = chk_q ^ rx_data;
                    lane_d = lane_q + 2'd1;
                    case (lane_q)
                        2'd0: wbuf_d[7:0]   = rx_data;
                        2'd1: wbuf_d[15:8]  = rx_data;
                        2'd2: wbuf_d[23:16] = rx_data;
                        default: begin
                            im_we_d      = 1'b1;
                            im_addr_d    = word_count_q[ADDR_W-1:0];
                            im_wdata_d   = {rx_data, wbuf_q};
                            word_count_d = word_count_q + CNT_W'(1);
                            if (word_count_q + CNT_W'(1) == n_q) begin
                                state_d = S_CHK;
                            end
                        end
                    endcase
                end
            end
            S_CHK: begin
                if (accept_c) begin
                    if (rx_data == chk_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Ready/busy registered from the next state so they track state_q exactly
        rx_ready_d = (state_d == S_LEN0) || (state_d == S_LEN1) ||
                     (state_d == S_DATA) || (state_d == S_CHK);
        busy_d     = rx_ready_d;
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            len_lo_q     <= '0;
            n_q          <= '0;
            lane_q       <= '0;
            chk_q        <= '0;
            wbuf_q       <= '0;
            word_count_q <= '0;
            im_we_q      <= 1'b0;
            im_addr_q    <= '0;
            im_wdata_q   <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            rx_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_lo_q     <= len_lo_d;
            n_q          <= n_d;
            lane_q       <= lane_d;
            chk_q        <= chk_d;
            wbuf_q       <= wbuf_d;
            word_count_q <= word_count_d;
            im_we_q      <= im_we_d;
            im_addr_q    <= im_addr_d;
            im_wdata_q   <= im_wdata_d;
            done_q       <= done_d;
            error_q      <= error_d;
            rx_ready_q   <= rx_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign rx_ready   = rx_ready_q;
    assign im_we      = im_we_q;
    assign im_addr    = im_addr_q;
    assign im_wdata   = im_wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign word_count = word_count_q;

endmodule
